// File: rtl/request_arbiter.sv
// rtl/request_arbiter.sv - arbitrates fetch and data clients onto one shared memory bus
// Optional performance counters are enabled by defining REQUEST_ARBITER_PERF_EN.
module request_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  i_req,
  input  logic [ADDR_W-1:0]     i_addr,
  output logic [DATA_W-1:0]     i_rdata,
  output logic                  i_valid,
  input  logic                  d_ren,
  input  logic                  d_wen,
  input  logic [ADDR_W-1:0]     d_addr,
  input  logic [DATA_W-1:0]     d_wdata,
  input  logic [DATA_W/8-1:0]   d_strb,
  output logic [DATA_W-1:0]     d_rdata,
  output logic                  d_valid,
  output logic                  mem_ren,
  output logic                  mem_wen,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [DATA_W/8-1:0]   mem_strb,
  input  logic [DATA_W-1:0]     mem_rdata,
  input  logic                  mem_ready,
  output logic                  stall
`ifdef REQUEST_ARBITER_PERF_EN
  ,
  output logic [CNT_W-1:0]      perf_ifetch,
  output logic [CNT_W-1:0]      perf_dacc,
  output logic [CNT_W-1:0]      perf_stall
`endif
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] IBUS = 2'd1;
  localparam logic [1:0] DBUS = 2'd2;
  localparam logic [1:0] RESP = 2'd3;
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15 || (DATA_W % 8) != 0 || CNT_W < 1) begin : g_bad_param
    $error("request_arbiter: illegal parameter combination");
  end

  logic [1:0] state;
  logic [3:0] starve_cnt;
  logic       d_req;
  logic       starved;

  assign d_req   = d_ren | d_wen;
  assign starved = i_req && (starve_cnt == LIMIT);
  assign stall   = (i_req & ~i_valid) | (d_req & ~d_valid);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      starve_cnt <= '0;
      mem_ren    <= 1'b0;
      mem_wen    <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_strb   <= '0;
      i_rdata    <= '0;
      i_valid    <= 1'b0;
      d_rdata    <= '0;
      d_valid    <= 1'b0;
    end else begin
      i_valid <= 1'b0;
      d_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (d_req && !starved) begin
            // A simultaneous read and write request is issued as a write.
            state     <= DBUS;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            mem_strb  <= d_wen ? d_strb : '1;
            mem_ren   <= ~d_wen;
            mem_wen   <= d_wen;
            if (!i_req) begin
              starve_cnt <= '0;
            end else if (starve_cnt != LIMIT) begin
              starve_cnt <= starve_cnt + 4'd1;
            end
          end else if (i_req) begin
            state      <= IBUS;
            mem_addr   <= i_addr;
            mem_wdata  <= '0;
            mem_strb   <= '1;
            mem_ren    <= 1'b1;
            mem_wen    <= 1'b0;
            starve_cnt <= '0;
          end else begin
            starve_cnt <= '0;
          end
        end
        IBUS: begin
          if (mem_ready) begin
            i_rdata <= mem_rdata;
            i_valid <= 1'b1;
            mem_ren <= 1'b0;
            mem_wen <= 1'b0;
            state   <= RESP;
          end
        end
        DBUS: begin
          if (mem_ready) begin
            if (!mem_wen) begin
              d_rdata <= mem_rdata;
            end
            d_valid <= 1'b1;
            mem_ren <= 1'b0;
            mem_wen <= 1'b0;
            state   <= RESP;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef REQUEST_ARBITER_PERF_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      perf_ifetch <= '0;
      perf_dacc   <= '0;
      perf_stall  <= '0;
    end else begin
      if (i_valid && perf_ifetch != '1) perf_ifetch <= perf_ifetch + CNT_W'(1);
      if (d_valid && perf_dacc != '1)   perf_dacc   <= perf_dacc + CNT_W'(1);
      if (stall && perf_stall != '1)    perf_stall  <= perf_stall + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_request_arbiter.sv
// tb/tb_request_arbiter.sv - randomized scoreboard bench for request_arbiter
module tb_request_arbiter;

  localparam int LIMIT = 2;
  localparam byte CH_D = 8'h44;
  localparam byte CH_I = 8'h49;

  logic        CLK;
  logic        RST;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_valid;
  logic        d_ren;
  logic        d_wen;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_strb;
  logic [31:0] d_rdata;
  logic        d_valid;
  logic        mem_ren;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_strb;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        stall;
`ifdef REQUEST_ARBITER_PERF_EN
  logic [15:0] perf_ifetch;
  logic [15:0] perf_dacc;
  logic [15:0] perf_stall;
`endif

  request_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(LIMIT), .CNT_W(16)) dut (
    .CLK(CLK), .RST(RST),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_valid(i_valid),
    .d_ren(d_ren), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata), .d_strb(d_strb),
    .d_rdata(d_rdata), .d_valid(d_valid),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_strb(mem_strb), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .stall(stall)
`ifdef REQUEST_ARBITER_PERF_EN
    , .perf_ifetch(perf_ifetch), .perf_dacc(perf_dacc), .perf_stall(perf_stall)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    bit          is_d;
    bit          ren;
    bit          wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
  } bus_t;

  typedef struct {
    bit          is_d;
    logic [31:0] rdata;
  } rsp_t;

  bus_t exp_bus[$];
  rsp_t exp_rsp[$];
  byte  grant_log[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   valid_count = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Client drivers: mode 0 = idle, 1 = random requests with gaps, 2 = requests held back to back.
  int f_mode = 0, d_mode = 0;
  bit f_pend = 0, d_pend = 0;
  int f_gap = 0, d_gap = 0;

  always @(negedge CLK) begin
    if (f_mode == 0) begin
      i_req = 1'b0; f_pend = 0; f_gap = 0;
    end else if (f_pend) begin
      if (i_valid) begin
        if (f_mode == 2) i_addr = $urandom;
        else begin i_req = 1'b0; f_pend = 0; f_gap = $urandom_range(0, 3); end
      end
    end else if (f_gap > 0) begin
      f_gap--;
    end else begin
      i_req = 1'b1; i_addr = $urandom; f_pend = 1;
    end
  end

  task automatic new_data_req();
    int k;
    k = $urandom_range(0, 3);
    d_ren   = (k != 2);
    d_wen   = (k >= 2);
    d_addr  = $urandom;
    d_wdata = $urandom;
    d_strb  = 4'($urandom);
  endtask

  always @(negedge CLK) begin
    if (d_mode == 0) begin
      d_ren = 1'b0; d_wen = 1'b0; d_pend = 0; d_gap = 0;
    end else if (d_pend) begin
      if (d_valid) begin
        if (d_mode == 2) begin d_ren = 1'b1; d_wen = 1'b0; d_addr = $urandom; end
        else begin d_ren = 1'b0; d_wen = 1'b0; d_pend = 0; d_gap = $urandom_range(0, 3); end
      end
    end else if (d_gap > 0) begin
      d_gap--;
    end else begin
      new_data_req();
      if (d_mode == 2) begin d_ren = 1'b1; d_wen = 1'b0; end
      d_pend = 1;
    end
  end

  // Memory: completes each transaction after 0..3 extra cycles; may also fire stray ready pulses.
  bit mem_busy = 0;
  int mem_wait = 0;
  int spur_cnt = 0, spur_seen = 0;
  bit spur_rand = 0;

  always @(negedge CLK) begin
    mem_ready = 1'b0;
    if (mem_ren || mem_wen) begin
      if (!mem_busy) begin mem_busy = 1; mem_wait = $urandom_range(0, 3); end
      if (mem_wait == 0) begin
        mem_ready = 1'b1; mem_rdata = $urandom; mem_busy = 0;
      end else begin
        mem_wait--;
      end
    end else begin
      mem_busy = 0;
      if (spur_cnt != spur_seen || (spur_rand && $urandom_range(0, 5) == 0)) begin
        if (spur_cnt != spur_seen) spur_seen++;
        mem_ready = 1'b1; mem_rdata = $urandom;
      end
    end
  end

  // Reference model: one outstanding bus transaction, one response cycle, starvation-bounded priority.
  int          phase = 0;
  int          starve = 0;
  bit          own_d = 0;
  bit          own_wr = 0;
  logic [31:0] last_i = '0, last_d = '0;

  always @(posedge CLK) begin
    bus_t b;
    if (RST) begin
      phase = 0; starve = 0; last_i = '0; last_d = '0;
      exp_bus.delete(); exp_rsp.delete();
    end else if (phase == 0) begin
      if ((d_ren || d_wen) && !(i_req && starve == LIMIT)) begin
        b.is_d = 1; b.wen = d_wen; b.ren = !d_wen; b.addr = d_addr;
        b.wdata = d_wdata; b.strb = d_wen ? d_strb : 4'hF;
        exp_bus.push_back(b);
        own_d = 1; own_wr = d_wen; phase = 1;
        starve = i_req ? ((starve + 1 > LIMIT) ? LIMIT : starve + 1) : 0;
      end else if (i_req) begin
        b.is_d = 0; b.wen = 0; b.ren = 1; b.addr = i_addr; b.wdata = '0; b.strb = 4'hF;
        exp_bus.push_back(b);
        own_d = 0; phase = 1; starve = 0;
      end else begin
        starve = 0;
      end
    end else if (phase == 1) begin
      if (mem_ready) begin
        if (own_d) begin
          if (!own_wr) last_d = mem_rdata;
          exp_rsp.push_back('{is_d: 1, rdata: last_d});
        end else begin
          last_i = mem_rdata;
          exp_rsp.push_back('{is_d: 0, rdata: last_i});
        end
        phase = 2;
      end
    end else begin
      phase = 0;
    end
  end

  // Bus monitor: every new bus transaction must match the predicted grant and stay stable.
  bit   prev_strobe = 0;
  bus_t cur_bus;

  always @(negedge CLK) begin
    #1;
    if ((mem_ren || mem_wen) && !prev_strobe) begin
      check("bus_grant_expected", exp_bus.size() != 0, 1);
      if (exp_bus.size() != 0) begin
        cur_bus = exp_bus.pop_front();
        check("bus_addr", mem_addr, cur_bus.addr);
        check("bus_ren_wen", {mem_ren, mem_wen}, {cur_bus.ren, cur_bus.wen});
        check("bus_strb", mem_strb, cur_bus.strb);
        if (cur_bus.wen) check("bus_wdata", mem_wdata, cur_bus.wdata);
      end
    end else if (mem_ren || mem_wen) begin
      check("bus_hold", {mem_addr, mem_strb, mem_ren, mem_wen},
            {cur_bus.addr, cur_bus.strb, cur_bus.ren, cur_bus.wen});
    end
    prev_strobe = mem_ren || mem_wen;
  end

  // Response monitor: each valid pulse pops one predicted response.
  rsp_t mon_r;

  always @(negedge CLK) begin
    #1;
    check("stall", stall, (i_req & ~i_valid) | ((d_ren | d_wen) & ~d_valid));
    if (i_valid || d_valid) begin
      valid_count++;
      grant_log.push_back(d_valid ? CH_D : CH_I);
      check("single_valid", i_valid & d_valid, 0);
      check("rsp_expected", exp_rsp.size() != 0, 1);
      if (exp_rsp.size() != 0) begin
        mon_r = exp_rsp.pop_front();
        check("rsp_client", d_valid, mon_r.is_d);
        check("rsp_rdata", mon_r.is_d ? d_rdata : i_rdata, mon_r.rdata);
      end
    end
  end

  initial begin
    byte exp_seq[6];
    int  base;
    int  vcnt;
    bit  found;
    exp_seq = '{CH_D, CH_D, CH_I, CH_D, CH_D, CH_I};
    RST = 1'b1;
    i_req = 0; i_addr = '0; d_ren = 0; d_wen = 0; d_addr = '0; d_wdata = '0; d_strb = '0;
    mem_ready = 0; mem_rdata = '0;
    repeat (2) @(posedge CLK);
    @(negedge CLK); #1;
    check("rst_mem_strobes", {mem_ren, mem_wen}, 2'b00);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata_strb", {mem_wdata, mem_strb}, 0);
    check("rst_rdata", {i_rdata, d_rdata}, 0);
    check("rst_valids", {i_valid, d_valid}, 2'b00);
    @(negedge CLK); RST = 1'b0;

    f_mode = 1; d_mode = 1; spur_rand = 1;
    repeat (400) @(negedge CLK);
    f_mode = 2;
    repeat (200) @(negedge CLK);
    spur_rand = 0; f_mode = 0; d_mode = 0;
    repeat (20) @(negedge CLK);

    // Starvation ordering with both clients held continuously.
    RST = 1'b1;
    @(negedge CLK); RST = 1'b0;
    base = grant_log.size();
    f_mode = 2; d_mode = 2;
    repeat (80) @(negedge CLK);
    check("starve_log_len", grant_log.size() - base >= 6, 1);
    for (int k = 0; k < 6; k++)
      if (base + k < grant_log.size()) check("starve_order", grant_log[base + k], exp_seq[k]);
    f_mode = 0; d_mode = 0;
    repeat (20) @(negedge CLK);

    // Reset while a data transaction is on the bus, then a late mem_ready.
    d_mode = 1;
    found = 0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge CLK);
      if (mem_ren || mem_wen) found = 1;
    end
    check("dbus_reached", found, 1);
    RST = 1'b1; d_mode = 0;
    vcnt = valid_count;
    @(negedge CLK); RST = 1'b0; spur_cnt++;
    repeat (5) @(negedge CLK);
    #1;
    check("midrst_no_valid", valid_count, vcnt);
    check("midrst_mem_out", {mem_ren, mem_wen, mem_addr, mem_strb}, 0);
    check("midrst_mem_wdata", mem_wdata, 0);

    // Stray mem_ready while idle.
    vcnt = valid_count;
    spur_cnt++;
    repeat (5) @(negedge CLK);
    #1;
    check("spur_no_valid", valid_count, vcnt);
    check("spur_no_bus", {mem_ren, mem_wen}, 2'b00);

    // Idle state confirmed by a fresh fetch being served.
    f_mode = 1;
    repeat (15) @(negedge CLK);
    f_mode = 0;
    repeat (15) @(negedge CLK);
    check("post_fetch_served", valid_count > vcnt, 1);
    check("rsp_queue_drained", exp_rsp.size(), 0);
    check("bus_queue_drained", exp_bus.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
